// File: rtl/tree_loader_pkg.sv
// Shared defaults, FSM state codes and the feature-index type for the tree
// feature loader.
package tree_loader_pkg;
  localparam int DEF_N_FEAT   = 16;
  localparam int DEF_FEAT_W   = 8;
  localparam int DEF_CLASS_W  = 4;
  localparam int DEF_TREE_LAT = 1;

  typedef logic [1:0] state_t;
  localparam state_t ST_LOAD = 2'd0;
  localparam state_t ST_EVAL = 2'd1;
  localparam state_t ST_OUT  = 2'd2;

  typedef logic [$clog2(DEF_N_FEAT)-1:0] feat_idx_t;
endpackage

// File: rtl/frame_byte_counter.sv
// Tracks the byte position inside a frame. It flags frames that end early or
// run long, and swallows the tail of a long frame up to its s_last.
module frame_byte_counter
  import tree_loader_pkg::*;
#(
  parameter int  N_FEAT = DEF_N_FEAT,
  localparam int IW     = $clog2(N_FEAT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          xfer,
  input  logic          last,
  output logic          wr_en,
  output logic [IW-1:0] wr_idx,
  output logic          frame_done,
  output logic          frame_err
);

  logic [IW-1:0] idx;
  logic          drain;
  logic          at_end;

  assign at_end     = (idx == IW'(N_FEAT - 1));
  assign wr_en      = xfer & ~drain;
  assign wr_idx     = idx;
  assign frame_done = wr_en & last & at_end;
  // s_last before the final slot is short; no s_last on the final slot is long
  assign frame_err  = wr_en & (last ^ at_end);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx   <= '0;
      drain <= 1'b0;
    end else if (xfer) begin
      if (drain) begin
        if (last) drain <= 1'b0;
      end else if (last || at_end) begin
        idx   <= '0;
        drain <= ~last;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tree_feature_loader.sv
// Assembles a byte stream into one feature frame and holds it steady for the
// combinational tree. After the settle time it samples the class label and
// returns it over a valid/ready port.
module tree_feature_loader
  import tree_loader_pkg::*;
#(
  parameter int N_FEAT   = DEF_N_FEAT,
  parameter int FEAT_W   = DEF_FEAT_W,
  parameter int CLASS_W  = DEF_CLASS_W,
  parameter int TREE_LAT = DEF_TREE_LAT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  input  logic [FEAT_W-1:0]        s_data,
  input  logic                     s_last,
  output logic                     s_ready,
  output logic [N_FEAT*FEAT_W-1:0] feat_bus,
  output logic                     feat_valid,
  input  logic [CLASS_W-1:0]       cls_in,
  output logic                     m_valid,
  output logic [CLASS_W-1:0]       m_class,
  input  logic                     m_ready,
  output logic                     err_frame
);

  localparam int IW = $clog2(N_FEAT);
  localparam int CW = $clog2(TREE_LAT + 1);

  generate
    if (TREE_LAT < 1) begin : g_bad_lat
      $error("tree_feature_loader: TREE_LAT must be >= 1");
    end
  endgenerate

  state_t                         state;
  logic [CW-1:0]                  cnt;
  logic [N_FEAT-1:0][FEAT_W-1:0]  feat_q;
  logic                           xfer;
  logic                           wr_en;
  logic [IW-1:0]                  wr_idx;
  logic                           frame_done;
  logic                           frame_err;

  assign s_ready  = (state == ST_LOAD);
  assign xfer     = s_valid & s_ready;
  assign feat_bus = feat_q;

  frame_byte_counter #(.N_FEAT(N_FEAT)) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .xfer       (xfer),
    .last       (s_last),
    .wr_en      (wr_en),
    .wr_idx     (wr_idx),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  // Writes happen only in LOAD, so the frame is frozen for the whole evaluation
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        feat_q         <= '0;
    else if (wr_en) feat_q[wr_idx] <= s_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_LOAD;
      cnt        <= '0;
      feat_valid <= 1'b0;
      m_valid    <= 1'b0;
      m_class    <= '0;
      err_frame  <= 1'b0;
    end else begin
      err_frame <= frame_err;
      case (state)
        ST_LOAD: begin
          cnt <= '0;
          if (frame_done) begin
            state      <= ST_EVAL;
            feat_valid <= 1'b1;
          end
        end
        ST_EVAL: begin
          if (cnt == CW'(TREE_LAT - 1)) begin
            m_class <= cls_in;
            m_valid <= 1'b1;
            state   <= ST_OUT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_OUT: begin
          if (m_ready) begin
            m_valid    <= 1'b0;
            feat_valid <= 1'b0;
            state      <= ST_LOAD;
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_tree_feature_loader.sv
// Bench for tree_feature_loader: directed corner cases, a table of frames,
// and a randomized stream checked against a frame-level scoreboard.
module tb_tree_feature_loader;
  localparam int NF = 16;
  localparam int FW = 8;
  localparam int CW = 4;
  localparam int TL = 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              s_valid = 1'b0;
  logic [FW-1:0]     s_data = '0;
  logic              s_last = 1'b0;
  logic              s_ready;
  logic [NF*FW-1:0]  feat_bus;
  logic              feat_valid;
  logic [CW-1:0]     cls_in;
  logic              m_valid;
  logic [CW-1:0]     m_class;
  logic              m_ready = 1'b0;
  logic              err_frame;

  always #5 clk = ~clk;

  // Tree stand-in: class is the low nibble of the last feature
  assign cls_in = feat_bus[(NF-1)*FW +: CW];

  tree_feature_loader #(.N_FEAT(NF), .FEAT_W(FW), .CLASS_W(CW), .TREE_LAT(TL)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready), .feat_bus(feat_bus), .feat_valid(feat_valid), .cls_in(cls_in),
    .m_valid(m_valid), .m_class(m_class), .m_ready(m_ready), .err_frame(err_frame)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NF*FW-1:0] ramp_bus(input logic [7:0] lastb);
    logic [NF*FW-1:0] b;
    for (int k = 0; k < NF; k++) b[k*FW +: FW] = (k == NF-1) ? lastb : 8'(k);
    return b;
  endfunction

  // Starts and ends on a falling edge; assumes the loader is in LOAD
  task automatic send_bytes(input int len, input logic [7:0] lastb, output int errs);
    errs = 0;
    for (int k = 0; k < len; k++) begin
      s_valid = 1'b1;
      s_data  = (k == len-1) ? lastb : 8'(k);
      s_last  = (k == len-1);
      @(negedge clk);
      if (err_frame) errs++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic finish_frame(input string tag, input bit exp_err, input logic [3:0] exp_cls,
                              input int errs_in);
    int errs;
    int lat;
    errs = errs_in;
    lat  = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (err_frame) errs++;
      if (m_valid) begin
        lat = c;
        break;
      end
    end
    if (exp_err) begin
      check({tag, "_err_pulses"}, 128'(errs), 1);
      check({tag, "_no_result"}, 128'(lat), 0);
    end else begin
      check({tag, "_no_err"}, 128'(errs), 0);
      check({tag, "_latency"}, 128'(lat), 1);
      check({tag, "_class"}, m_class, exp_cls);
      check({tag, "_feat_valid"}, feat_valid, 1);
      m_ready = 1'b1;
      @(negedge clk);
      check({tag, "_m_valid_clr"}, m_valid, 0);
      check({tag, "_s_ready_back"}, s_ready, 1);
      m_ready = 1'b0;
    end
  endtask

  typedef struct {
    int         len;
    logic [7:0] lastb;
    bit         exp_err;
    logic [3:0] exp_cls;
  } vec_t;

  typedef struct {
    bit               err;
    logic [3:0]       cls;
    logic [NF*FW-1:0] feats;
  } ev_t;

  initial begin
    vec_t tbl[6];
    ev_t  evq[$];
    ev_t  ev;
    logic [7:0] sd[$];
    bit         sl[$];
    int e;
    int si;
    int cyc;

    tbl[0] = '{10, 8'h0A, 1'b1, 4'h0};
    tbl[1] = '{16, 8'h3C, 1'b0, 4'hC};
    tbl[2] = '{17, 8'h55, 1'b1, 4'h0};
    tbl[3] = '{16, 8'h07, 1'b0, 4'h7};
    tbl[4] = '{ 1, 8'h01, 1'b1, 4'h0};
    tbl[5] = '{16, 8'hF9, 1'b0, 4'h9};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_m_valid", m_valid, 0);
    check("rst_feat_valid", feat_valid, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rel_s_ready", s_ready, 1);
    check("rel_feat_bus", feat_bus, 0);
    check("rel_feat_valid", feat_valid, 0);
    check("rel_m_valid", m_valid, 0);
    check("rel_m_class", m_class, 0);
    check("rel_err_frame", err_frame, 0);

    // Ramp frame, then hold the result with m_ready low while s_valid pokes at it
    send_bytes(16, 8'h0F, e);
    check("ramp_feat_valid", feat_valid, 1);
    check("ramp_s_ready", s_ready, 0);
    check("ramp_m_valid_early", m_valid, 0);
    check("ramp_feat_bus", feat_bus, ramp_bus(8'h0F));
    @(negedge clk);
    check("ramp_m_valid", m_valid, 1);
    check("ramp_m_class", m_class, 4'hF);
    s_valid = 1'b1; s_data = 8'hAA; s_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_m_valid", m_valid, 1);
      check("hold_m_class", m_class, 4'hF);
      check("hold_feat_bus", feat_bus, ramp_bus(8'h0F));
      check("hold_s_ready", s_ready, 0);
    end
    s_valid = 1'b0; s_last = 1'b0;
    m_ready = 1'b1;
    #1 check("hs_no_bypass", s_ready, 0);
    @(negedge clk);
    check("hs_m_valid", m_valid, 0);
    check("hs_feat_valid", feat_valid, 0);
    check("hs_s_ready", s_ready, 1);
    m_ready = 1'b0;

    // m_ready high in advance: handshake on the first OUT cycle
    m_ready = 1'b1;
    send_bytes(16, 8'h07, e);
    check("adv_m_valid_early", m_valid, 0);
    @(negedge clk);
    check("adv_m_valid", m_valid, 1);
    check("adv_m_class", m_class, 4'h7);
    @(negedge clk);
    check("adv_m_valid_clr", m_valid, 0);
    check("adv_s_ready", s_ready, 1);
    m_ready = 1'b0;

    // Table of good and malformed frames
    for (int t = 0; t < 6; t++) begin
      send_bytes(tbl[t].len, tbl[t].lastb, e);
      finish_frame($sformatf("tbl%0d", t), tbl[t].exp_err, tbl[t].exp_cls, e);
    end

    // Reset while evaluating
    send_bytes(16, 8'h05, e);
    check("pre_rst_feat_valid", feat_valid, 1);
    rst = 1'b1;
    #1;
    check("arst_feat_valid", feat_valid, 0);
    check("arst_m_valid", m_valid, 0);
    check("arst_m_class", m_class, 0);
    check("arst_feat_bus", feat_bus, 0);
    check("arst_err_frame", err_frame, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_bytes(16, 8'h0A, e);
    finish_frame("post_rst", 1'b0, 4'hA, e);

    // Random stream scored per frame: 16 bytes -> result, anything else -> one error
    for (int f = 0; f < 40; f++) begin
      int r;
      int len;
      logic [NF*FW-1:0] fb;
      logic [7:0] d;
      r   = $urandom_range(0, 9);
      len = (r < 7) ? 16 : (r < 9) ? $urandom_range(1, 15) : $urandom_range(17, 20);
      fb  = '0;
      for (int b = 0; b < len; b++) begin
        d = 8'($urandom);
        sd.push_back(d);
        sl.push_back(b == len-1);
        if (b < NF) fb[b*FW +: FW] = d;
      end
      if (len == NF) evq.push_back('{1'b0, fb[(NF-1)*FW +: CW], fb});
      else           evq.push_back('{1'b1, 4'h0, '0});
    end

    si  = 0;
    cyc = 0;
    while ((si < sd.size() || evq.size() > 0) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (err_frame) begin
        if (evq.size() == 0) check("rnd_spurious_err", 1, 0);
        else begin
          ev = evq.pop_front();
          check("rnd_err_expected", ev.err, 1);
        end
      end
      if (si < sd.size()) begin
        s_valid = ($urandom_range(0, 3) != 0);
        s_data  = sd[si];
        s_last  = sl[si];
      end else begin
        s_valid = 1'b0;
        s_last  = 1'b0;
      end
      m_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (s_valid && s_ready) si++;
      if (m_valid && m_ready) begin
        if (evq.size() == 0) check("rnd_spurious_result", 1, 0);
        else begin
          ev = evq.pop_front();
          check("rnd_result_expected", ev.err, 0);
          check("rnd_class", m_class, ev.cls);
          check("rnd_feat_bus", feat_bus, ev.feats);
          check("rnd_feat_valid", feat_valid, 1);
        end
      end
    end
    check("rnd_all_consumed", 128'(evq.size() + (sd.size() - si)), 0);
    s_valid = 1'b0;
    m_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
